guess_submit: RTL

GUESS_SUBMIT -- requirements
Module: guess_submit

---
 rtl/guess_submit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/guess_submit.sv
`default_nettype none
// ============================================================================
//  Module      : guess_submit
//  Description : Guess entry and submission controller for one game round.
//                Collects four shape digits, hands the guess to the grader,
//                records the grader's answer and decides win / lose / retry.
//  Revision    : 1.0  initial release
// ============================================================================
module guess_submit #(
    parameter int MAX_GUESSES = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        StartGame,
    input  logic [4:0]  NumRounds,
    input  logic [2:0]  GuessShape,
    input  logic [1:0]  GuessLocation,
    input  logic        LoadGuessNow,
    input  logic        SubmitGuess,
    input  logic        GuessReady,
    input  logic [3:0]  Znarly,
    input  logic [3:0]  Zood,
    output logic [11:0] Guess,
    output logic        GradeIt,
    output logic        GuessLoaded,
    output logic        ConsumeRound,
    output logic [3:0]  GuessCount,
    output logic [3:0]  LastZnarly,
    output logic [3:0]  LastZood,
    output logic        GameWon,
    output logic        GameOver
);

    localparam logic [3:0] c_max_guesses = 4'(MAX_GUESSES);
    localparam logic [3:0] c_win_znarly  = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_SUBMIT = 3'd2,
        S_RESULT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_guess;
    logic [3:0]  r_written;
    logic [3:0]  r_count;
    logic [3:0]  r_last_znarly;
    logic [3:0]  r_last_zood;
    logic        r_won;
    logic        r_over;
    logic        w_consume;
    logic        w_grade;
    logic        w_loaded;
    logic        w_shape_legal;
    logic        w_load_ok;

    // A digit may be written once per guess and only with a real shape code.
    assign w_loaded      = &r_written;
    assign w_shape_legal = (GuessShape != 3'd0) && (GuessShape != 3'd7);
    assign w_load_ok     = LoadGuessNow && w_shape_legal && !r_written[GuessLocation];

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the two combinational strobes.
    always_comb begin
        w_state_next = r_state;
        w_consume    = 1'b0;
        w_grade      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (StartGame && (NumRounds != 5'd0)) begin
                    w_consume    = 1'b1;
                    w_state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                // Submit is judged on the flags as they stand before this edge.
                if (SubmitGuess && w_loaded) begin
                    w_state_next = S_SUBMIT;
                end
            end
            S_SUBMIT: begin
                w_grade = 1'b1;
                if (GuessReady) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if ((r_last_znarly == c_win_znarly) || (r_count == c_max_guesses)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ENTRY;
                end
            end
            S_DONE: begin
                if (StartGame) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Reset silences both strobes in the cycle it is applied.
        if (reset) begin
            w_consume = 1'b0;
            w_grade   = 1'b0;
        end
    end

    // Round datapath: digits, written flags, counters and verdict flags.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_guess       <= 12'd0;
            r_written     <= 4'd0;
            r_count       <= 4'd0;
            r_last_znarly <= 4'd0;
            r_last_zood   <= 4'd0;
            r_won         <= 1'b0;
            r_over        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_consume) begin
                        r_guess       <= 12'd0;
                        r_written     <= 4'd0;
                        r_count       <= 4'd0;
                        r_last_znarly <= 4'd0;
                        r_last_zood   <= 4'd0;
                    end
                end
                S_ENTRY: begin
                    if (w_load_ok) begin
                        r_written[GuessLocation] <= 1'b1;
                        case (GuessLocation)
                            2'd0:    r_guess[11:9] <= GuessShape;
                            2'd1:    r_guess[8:6]  <= GuessShape;
                            2'd2:    r_guess[5:3]  <= GuessShape;
                            default: r_guess[2:0]  <= GuessShape;
                        endcase
                    end
                end
                S_SUBMIT: begin
                    if (GuessReady) begin
                        r_last_znarly <= Znarly;
                        r_last_zood   <= Zood;
                        // Saturate so the count can never pass the round limit.
                        if (r_count != c_max_guesses) begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (r_last_znarly == c_win_znarly) begin
                        r_won <= 1'b1;
                    end else if (r_count == c_max_guesses) begin
                        r_over <= 1'b1;
                    end else begin
                        r_guess   <= 12'd0;
                        r_written <= 4'd0;
                    end
                end
                S_DONE: begin
                    if (StartGame) begin
                        r_won  <= 1'b0;
                        r_over <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Guess        = r_guess;
    assign GradeIt      = w_grade;
    assign GuessLoaded  = w_loaded;
    assign ConsumeRound = w_consume;
    assign GuessCount   = r_count;
    assign LastZnarly   = r_last_znarly;
    assign LastZood     = r_last_zood;
    assign GameWon      = r_won;
    assign GameOver     = r_over;

endmodule
`default_nettype wire
